// File: rtl/ad9361_rx_pkg.sv
// Shared widths, pairing state and sign extension for the AD9361 RX packer.
// AD9361_RX_PACK_SWAP_EN (top level) selects Q-first lane order.
package ad9361_rx_pkg;

  localparam int SAMPLE_W = 12;
  localparam int LANE_W   = 16;

  typedef enum logic {
    WAIT_CH0,
    WAIT_CH1
  } pair_state_t;

  function automatic logic [LANE_W-1:0] sext(
    input logic [SAMPLE_W-1:0] s
  );
    return {{(LANE_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/rx_sample_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Write is accepted when not full or when a read happens in the same cycle.
module rx_sample_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_wr;
  logic             do_rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign level = cnt_q;

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Empty FIFO shows zero so the output bus is clean after reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ad9361_rx_pair_packer.sv
// Pairs AD9361 ch0/ch1 I/Q samples into 64-bit words and buffers them.
// Define AD9361_RX_PACK_SWAP_EN for {i1,q1,i0,q0} (Q-first lanes).
module ad9361_rx_pair_packer
  import ad9361_rx_pkg::*;
#(
  parameter int  FIFO_DEPTH = 16,
  parameter int  CNT_WIDTH  = 16,
  localparam int LW         = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                valid_0,
  input  logic [SAMPLE_W-1:0] data_i0,
  input  logic [SAMPLE_W-1:0] data_q0,
  input  logic                valid_1,
  input  logic [SAMPLE_W-1:0] data_i1,
  input  logic [SAMPLE_W-1:0] data_q1,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [63:0]         m_data,
  output logic [LW:0]         level,
  output logic                overflow,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic [CNT_WIDTH-1:0] misalign_count
);

  function automatic logic [63:0] pack(
    input logic [LANE_W-1:0] i0,
    input logic [LANE_W-1:0] q0,
    input logic [LANE_W-1:0] i1,
    input logic [LANE_W-1:0] q1
  );
`ifdef AD9361_RX_PACK_SWAP_EN
    return {i1, q1, i0, q0};
`else
    return {q1, i1, q0, i0};
`endif
  endfunction

  logic              en_s1_q;
  logic              v0_s1_q;
  logic              v1_s1_q;
  logic [LANE_W-1:0] i0_s1_q;
  logic [LANE_W-1:0] q0_s1_q;
  logic [LANE_W-1:0] i1_s1_q;
  logic [LANE_W-1:0] q1_s1_q;

  pair_state_t       state_q;
  logic [LANE_W-1:0] c0i_q;
  logic [LANE_W-1:0] c0q_q;
  logic              pair_vld_q;
  logic [63:0]       pair_q;
  logic [CNT_WIDTH-1:0] mis_q;

  logic              s2_vld_q;
  logic [63:0]       s2_data_q;
  logic              ovf_q;
  logic [CNT_WIDTH-1:0] ovf_cnt_q;

  logic              ff_full;
  logic              ff_empty;
  logic              pop;
  logic              push;
  logic              drop;
  logic              mis_sat;
  logic              ovf_sat;

  assign mis_sat = &mis_q;
  assign ovf_sat = &ovf_cnt_q;

  // S1: register every pin, widen samples to lane width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_s1_q <= 1'b0;
      v0_s1_q <= 1'b0;
      v1_s1_q <= 1'b0;
      i0_s1_q <= '0;
      q0_s1_q <= '0;
      i1_s1_q <= '0;
      q1_s1_q <= '0;
    end else begin
      en_s1_q <= enable;
      v0_s1_q <= valid_0;
      v1_s1_q <= valid_1;
      i0_s1_q <= sext(data_i0);
      q0_s1_q <= sext(data_q0);
      i1_s1_q <= sext(data_i1);
      q1_s1_q <= sext(data_q1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_CH0;
      c0i_q      <= '0;
      c0q_q      <= '0;
      pair_vld_q <= 1'b0;
      pair_q     <= '0;
      mis_q      <= '0;
    end else begin
      pair_vld_q <= 1'b0;
      if (!en_s1_q) begin
        state_q <= WAIT_CH0;
      end else begin
        unique case (state_q)
          WAIT_CH0: begin
            if (v0_s1_q && !v1_s1_q) begin
              c0i_q   <= i0_s1_q;
              c0q_q   <= q0_s1_q;
              state_q <= WAIT_CH1;
            end else if (v0_s1_q && v1_s1_q) begin
              pair_vld_q <= 1'b1;
              pair_q     <= pack(i0_s1_q, q0_s1_q,
                                 i1_s1_q, q1_s1_q);
            end else if (v1_s1_q) begin
              if (!mis_sat) mis_q <= mis_q + CNT_WIDTH'(1);
            end
          end
          WAIT_CH1: begin
            if (v1_s1_q && !v0_s1_q) begin
              pair_vld_q <= 1'b1;
              pair_q     <= pack(c0i_q, c0q_q,
                                 i1_s1_q, q1_s1_q);
              state_q    <= WAIT_CH0;
            end else if (v0_s1_q && !v1_s1_q) begin
              c0i_q <= i0_s1_q;
              c0q_q <= q0_s1_q;
              if (!mis_sat) mis_q <= mis_q + CNT_WIDTH'(1);
            end else if (v0_s1_q && v1_s1_q) begin
              // Pair the stale ch0, keep the new ch0 for the next ch1.
              pair_vld_q <= 1'b1;
              pair_q     <= pack(c0i_q, c0q_q,
                                 i1_s1_q, q1_s1_q);
              c0i_q      <= i0_s1_q;
              c0q_q      <= q0_s1_q;
              if (!mis_sat) mis_q <= mis_q + CNT_WIDTH'(1);
            end
          end
          default: state_q <= WAIT_CH0;
        endcase
      end
    end
  end

  assign pop  = m_valid & m_ready;
  assign push = s2_vld_q & (~ff_full | pop);
  assign drop = s2_vld_q & ff_full & ~pop;

  // S2 and drop accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      s2_vld_q  <= pair_vld_q;
      s2_data_q <= pair_q;
      if (drop) begin
        ovf_q <= 1'b1;
        if (!ovf_sat) ovf_cnt_q <= ovf_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  rx_sample_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (s2_data_q),
    .rd_en   (pop),
    .rd_data (m_data),
    .full    (ff_full),
    .empty   (ff_empty),
    .level   (level)
  );

  assign m_valid        = ~ff_empty;
  assign overflow       = ovf_q;
  assign ovf_count      = ovf_cnt_q;
  assign misalign_count = mis_q;

endmodule

// File: tb/tb_ad9361_rx_pair_packer.sv
// Directed, table-driven bench for ad9361_rx_pair_packer.
// Honours AD9361_RX_PACK_SWAP_EN when computing expected words.
module tb_ad9361_rx_pair_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        valid_0;
  logic [11:0] data_i0;
  logic [11:0] data_q0;
  logic        valid_1;
  logic [11:0] data_i1;
  logic [11:0] data_q1;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] ovf_count;
  logic [15:0] misalign_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  logic        sb_on = 1'b0;
  logic        stall_q = 1'b0;
  logic [63:0] hold_d = '0;

  always #5 clk = ~clk;

  ad9361_rx_pair_packer #(
    .FIFO_DEPTH (16),
    .CNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .valid_0        (valid_0),
    .data_i0        (data_i0),
    .data_q0        (data_q0),
    .valid_1        (valid_1),
    .data_i1        (data_i1),
    .data_q1        (data_q1),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .level          (level),
    .overflow       (overflow),
    .ovf_count      (ovf_count),
    .misalign_count (misalign_count)
  );

  typedef struct {
    logic [11:0] i0, q0, i1, q1;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [63:0] lanes(input logic [63:0] w);
`ifdef AD9361_RX_PACK_SWAP_EN
    return {w[47:32], w[63:48], w[15:0], w[31:16]};
`else
    return w;
`endif
  endfunction

  function automatic logic [15:0] sx(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  function automatic logic [63:0] expw(
    input logic [11:0] i0, q0, i1, q1
  );
    return lanes({sx(q1), sx(i1), sx(q0), sx(i0)});
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic sb_sample();
    if (stall_q) chk("hold", m_data, hold_d);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra actual=%h required=none", m_data);
      end else begin
        chk("sb_data", m_data, exp_q.pop_front());
      end
    end
    stall_q = m_valid && !m_ready;
    hold_d  = m_data;
  endtask

  task automatic step();
    @(negedge clk);
    if (sb_on) sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_0 = 1'b0;
    valid_1 = 1'b0;
  endtask

  task automatic drive_pair(input logic [11:0] i0, q0, i1, q1);
    valid_0 = 1'b1; data_i0 = i0; data_q0 = q0;
    valid_1 = 1'b1; data_i1 = i1; data_q1 = q1;
  endtask

  task automatic gen(input int k, output logic [11:0] i0, q0, i1, q1);
    i0 = 12'(k * 37);
    q0 = 12'(12'h800 + k);
    i1 = 12'(k * 5 + 1);
    q1 = 12'(12'hFFF - k);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b0;
    idle();
    data_i0 = '0; data_q0 = '0;
    data_i1 = '0; data_q1 = '0;
    sb_on = 1'b0;
    stall_q = 1'b0;
    exp_q.delete();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mvalid"}, 64'(m_valid), 64'd0);
    chk({tag, "_mdata"}, m_data, 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_ovfcnt"}, 64'(ovf_count), 64'd0);
    chk({tag, "_miscnt"}, 64'(misalign_count), 64'd0);
  endtask

  initial begin
    logic [11:0] a, b, c, d;
    logic [63:0] ev;
    int nw;

    tbl[0] = '{12'h7FF, 12'h800, 12'h001, 12'hFFF,
               64'hFFFF_0001_F800_07FF};
    tbl[1] = '{12'h000, 12'h000, 12'h000, 12'h000,
               64'h0000_0000_0000_0000};
    tbl[2] = '{12'h123, 12'h456, 12'h789, 12'hABC,
               64'hFABC_0789_0456_0123};
    tbl[3] = '{12'hFFF, 12'h001, 12'h800, 12'h7FF,
               64'h07FF_F800_0001_FFFF};
    tbl[4] = '{12'hA5A, 12'h5A5, 12'hF00, 12'h0F0,
               64'h00F0_FF00_05A5_FA5A};
    tbl[5] = '{12'h801, 12'h7FE, 12'hC00, 12'h3FF,
               64'h03FF_FC00_07FE_F801};

    do_reset();
    chk_zero("reset");

    // Normal stream: ch0 then ch1, latency of three edges.
    m_ready = 1'b1;
    valid_0 = 1'b1; data_i0 = 12'h7FF; data_q0 = 12'h800;
    step();
    valid_0 = 1'b0;
    valid_1 = 1'b1; data_i1 = 12'h001; data_q1 = 12'hFFF;
    step();
    idle();
    step();
    chk("lat_e1", 64'(m_valid), 64'd0);
    step();
    chk("lat_e2", 64'(m_valid), 64'd0);
    step();
    chk("lat_e3", 64'(m_valid), 64'd1);
    chk("lat_data", m_data, lanes(64'hFFFF_0001_F800_07FF));
    chk("lat_mis", 64'(misalign_count), 64'd0);
    step();
    chk("lat_drained", 64'(m_valid), 64'd0);

    // Table of simultaneous pairs, buffered then drained.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive_pair(tbl[k].i0, tbl[k].q0, tbl[k].i1, tbl[k].q1);
      step();
    end
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("tbl_level", 64'(level), 64'd6);
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("tbl_valid", 64'(m_valid), 64'd1);
      chk($sformatf("tbl_data%0d", k), m_data, lanes(tbl[k].exp));
      step();
    end
    chk("tbl_empty", 64'(m_valid), 64'd0);
    chk("tbl_mis", 64'(misalign_count), 64'd0);

    // Eight back-to-back simultaneous pairs, streaming.
    do_reset();
    m_ready = 1'b1;
    sb_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      gen(k, a, b, c, d);
      drive_pair(a, b, c, d);
      exp_q.push_back(expw(a, b, c, d));
      step();
    end
    idle();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    for (int k = 0; k < 3; k++) step();
    chk("burst_left", 64'(exp_q.size()), 64'd0);
    chk("burst_mis", 64'(misalign_count), 64'd0);
    sb_on = 1'b0;

    // Misalignment: lone ch1, ch0, ch0, ch1.
    do_reset();
    valid_1 = 1'b1; data_i1 = 12'h111; data_q1 = 12'h222;
    step();
    valid_1 = 1'b0;
    valid_0 = 1'b1; data_i0 = 12'h0AA; data_q0 = 12'h0AB;
    step();
    data_i0 = 12'h0BB; data_q0 = 12'h8BC;
    step();
    valid_0 = 1'b0;
    valid_1 = 1'b1; data_i1 = 12'h0CC; data_q1 = 12'hFCD;
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("mis_count", 64'(misalign_count), 64'd2);
    chk("mis_level", 64'(level), 64'd1);
    chk("mis_data", m_data, lanes(64'hFFCD_00CC_F8BC_00BB));

    // Enable drop mid-pair discards the half pair silently.
    do_reset();
    valid_0 = 1'b1; data_i0 = 12'h321; data_q0 = 12'h654;
    step();
    valid_0 = 1'b0; enable = 1'b0;
    valid_1 = 1'b1; data_i1 = 12'h0FE; data_q1 = 12'h0DC;
    step();
    idle(); enable = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("en_level", 64'(level), 64'd0);
    chk("en_mis", 64'(misalign_count), 64'd0);

    // Overflow: 20 pairs into 16 entries, no reads.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      gen(k, a, b, c, d);
      drive_pair(a, b, c, d);
      if (k < 16) exp_q.push_back(expw(a, b, c, d));
      step();
    end
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_cnt", 64'(ovf_count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    // Full FIFO, write coinciding with a pop must not drop.
    gen(100, a, b, c, d);
    drive_pair(a, b, c, d);
    step();
    idle();
    step();
    step();
    m_ready = 1'b1;
    chk("full_pop_head", m_data, exp_q.pop_front());
    exp_q.push_back(expw(a, b, c, d));
    step();
    m_ready = 1'b0;
    chk("full_pop_level", 64'(level), 64'd16);
    chk("full_pop_ovf", 64'(ovf_count), 64'd4);
    m_ready = 1'b1;
    nw = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_valid) begin
        nw++;
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          chk($sformatf("drain%0d", nw), m_data, ev);
        end else begin
          checks++;
          errors++;
          $display("FAIL drain_extra actual=%h required=none",
                   m_data);
        end
      end
      step();
    end
    chk("drain_words", 64'(nw), 64'd16);
    chk("drain_ovf_kept", 64'(overflow), 64'd1);

    // Backpressure: m_ready toggles under a continuous stream.
    do_reset();
    sb_on = 1'b1;
    for (int k = 0; k < 12; k++) begin
      gen(k + 40, a, b, c, d);
      drive_pair(a, b, c, d);
      exp_q.push_back(expw(a, b, c, d));
      m_ready = k[0];
      step();
    end
    idle();
    for (int k = 0; k < 40; k++) begin
      m_ready = ~m_ready;
      step();
    end
    chk("bp_left", 64'(exp_q.size()), 64'd0);
    chk("bp_ovf", 64'(ovf_count), 64'd0);
    sb_on = 1'b0;
    m_ready = 1'b0;

    // Asynchronous reset with five words buffered.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      gen(k + 60, a, b, c, d);
      drive_pair(a, b, c, d);
      step();
    end
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("ar_level", 64'(level), 64'd5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("areset");
    step();
    reset_n = 1'b1;
    step();
    m_ready = 1'b1;
    gen(77, a, b, c, d);
    drive_pair(a, b, c, d);
    step();
    idle();
    step();
    step();
    chk("ar_lat_e2", 64'(m_valid), 64'd0);
    step();
    chk("ar_valid", 64'(m_valid), 64'd1);
    chk("ar_data", m_data, expw(a, b, c, d));
    chk("ar_mis", 64'(misalign_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
